// File: rtl/key_encoder.sv
// Synchronises, debounces and priority-encodes eight active-low key lines.
// Optional: define MULTI_KEY_ERR_EN to flag accepted vectors holding more than one key.
module key_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] keys_n,
    output logic [2:0] code,
    output logic       key_valid,
    output logic       key_held,
    output logic       multi_err
);

    typedef enum logic [1:0] {StIdle, StDebPress, StPressed, StDebRelease} state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [7:0]       r_sync1;
    logic [7:0]       r_sync2;
    logic [7:0]       r_snap;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_code;
    logic             r_valid;
    logic             r_held;
    state_e           r_state;
    logic [7:0]       w_k;

    function automatic logic [2:0] prio_idx(input logic [7:0] v);
        prio_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) prio_idx = 3'(i);
        end
    endfunction

    assign w_k = ~r_sync2;

`ifdef MULTI_KEY_ERR_EN
    logic r_multi;
    logic w_add;
    // A newly pressed key on top of the accepted vector while it is still held.
    assign w_add     = ((w_k & ~r_snap) != 8'd0) && ($countones(w_k) > 1);
    assign multi_err = r_multi;
`else
    assign multi_err = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 8'hFF;
            r_sync2 <= 8'hFF;
        end else begin
            r_sync1 <= keys_n;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_snap  <= 8'd0;
            r_cnt   <= '0;
            r_code  <= 3'd0;
            r_valid <= 1'b0;
            r_held  <= 1'b0;
`ifdef MULTI_KEY_ERR_EN
            r_multi <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_k != 8'd0) begin
                        r_state <= StDebPress;
                        r_snap  <= w_k;
                        r_cnt   <= '0;
                    end
                end
                StDebPress: begin
                    if (w_k == 8'd0) begin
                        r_state <= StIdle;
                    end else if (w_k != r_snap) begin
                        r_snap <= w_k;
                        r_cnt  <= '0;
                    end else if (r_cnt == CntLast) begin
                        r_state <= StPressed;
                        r_code  <= prio_idx(r_snap);
                        r_valid <= 1'b1;
                        r_held  <= 1'b1;
`ifdef MULTI_KEY_ERR_EN
                        r_multi <= ($countones(r_snap) > 1);
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StPressed: begin
                    if (w_k == 8'd0) begin
                        r_state <= StDebRelease;
                        r_cnt   <= '0;
                    end
`ifdef MULTI_KEY_ERR_EN
                    else if (w_add) begin
                        r_multi <= 1'b1;
                    end
`endif
                end
                StDebRelease: begin
                    if (w_k != 8'd0) begin
                        // Release bounce: back to held without a new pulse.
                        r_state <= StPressed;
`ifdef MULTI_KEY_ERR_EN
                        if (w_add) r_multi <= 1'b1;
`endif
                    end else if (r_cnt == CntLast) begin
                        r_state <= StIdle;
                        r_held  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign code      = r_code;
    assign key_valid = r_valid;
    assign key_held  = r_held;

endmodule
